// File: rtl/ia_compressor.sv
// ia_compressor: drops zero activations from a dense channel-major tile stream and
// emits (value, h, w, c) entries through a small output FIFO, counting entries pushed.
// Latency: an accepted nonzero word reaches o_valid one cycle later when the FIFO is empty.
// Backpressure: o_ready falls while the FIFO holds FIFO_DEPTH entries, and a pop that cycle
//   does not raise it.
// Ports: i_clk/i_rst (sync, active-high), i_start + i_tile_h/i_tile_w tile setup,
//   i_valid/i_data/o_ready dense input, o_valid/i_ready/o_data/o_h/o_w/o_c_idx sparse output,
//   o_len/o_overflow tile statistics, o_busy/o_done status.
module ia_compressor #(
  parameter int CHANNELS   = 32,
  parameter int DATA_W     = 16,
  parameter int CAP        = 1200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [6:0]        i_tile_h,
  input  logic [6:0]        i_tile_w,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [6:0]        o_h,
  output logic [6:0]        o_w,
  output logic [4:0]        o_c_idx,
  output logic [10:0]       o_len,
  output logic              o_overflow,
  output logic              o_busy,
  output logic              o_done
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [6:0]        h;
    logic [6:0]        w;
    logic [4:0]        c;
  } entry_t;

  state_t           state_q, state_d;
  logic [6:0]       tile_h_q, tile_h_d, tile_w_q, tile_w_d;
  logic [6:0]       h_q, h_d, w_q, w_d;
  logic [4:0]       c_q, c_d;
  logic [10:0]      len_q, len_d;
  logic             ovf_q, ovf_d;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_full, fifo_empty, accept, push, pop, last_word, nonzero;
  entry_t           head;

  // Pointer wrap written explicitly so a depth of 1 also works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign o_ready    = (state_q == S_RUN) && !fifo_full;
  assign o_valid    = !fifo_empty;
  assign accept     = i_valid && o_ready;
  assign nonzero    = (i_data != '0);
  assign push       = accept && nonzero && (len_q < 11'(CAP));
  assign pop        = o_valid && i_ready;
  assign last_word  = (h_q == tile_h_q - 7'd1) && (w_q == tile_w_q - 7'd1) &&
                      (c_q == 5'(CHANNELS - 1));

  always_comb begin
    state_d  = state_q;
    tile_h_d = tile_h_q;
    tile_w_d = tile_w_q;
    h_d      = h_q;
    w_d      = w_q;
    c_d      = c_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_RUN;
          tile_h_d = i_tile_h;
          tile_w_d = i_tile_w;
          h_d      = '0;
          w_d      = '0;
          c_d      = '0;
          len_d    = '0;
          ovf_d    = 1'b0;
        end
      end
      S_RUN:   if (accept && last_word) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Position counters: c fastest, then w, then h. Only accepted words advance them,
    // and accept is only possible in S_RUN, so this never collides with the start clear.
    if (accept) begin
      if (c_q == 5'(CHANNELS - 1)) begin
        c_d = '0;
        if (w_q == tile_w_q - 7'd1) begin
          w_d = '0;
          h_d = h_q + 7'd1;
        end else begin
          w_d = w_q + 7'd1;
        end
      end else begin
        c_d = c_q + 5'd1;
      end
      // A nonzero that could not be pushed means the tile is already at capacity.
      if (nonzero && !push) ovf_d = 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = '{dat: i_data, h: h_q, w: w_q, c: c_q};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      len_d           = len_q + 11'd1;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      tile_h_q <= '0;
      tile_w_q <= '0;
      h_q      <= '0;
      w_q      <= '0;
      c_q      <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      // Storage is cleared too so the head outputs read 0 out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      tile_h_q <= tile_h_d;
      tile_w_q <= tile_w_d;
      h_q      <= h_d;
      w_q      <= w_d;
      c_q      <= c_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign o_data     = head.dat;
  assign o_h        = head.h;
  assign o_w        = head.w;
  assign o_c_idx    = head.c;
  assign o_len      = len_q;
  assign o_overflow = ovf_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE);

endmodule

// File: doc/ia_compressor.md
# ia_compressor

Upstream feeder for the sparse PE. It accepts a dense, channel-major activation stream for one tile of i_tile_h × i_tile_w pixels, discards zero activations, and emits a compressed stream of (value, h, w, channel index) entries. The PE's IA bundle is loaded from this stream. The block also reports the compressed entry count, which becomes the PE's IA length.

## Interface
Parameters:
- CHANNELS, 32: channels per pixel vector; must be ≤ 32 so the channel index fits 5 bits.
- DATA_W, 16: signed activation width.
- CAP, 1200: maximum compressed entries per tile (PE IA buffer depth).
- FIFO_DEPTH, 4: output FIFO entries; power of two.

Ports (clock and reset first):
- i_clk  in  1  sole clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins a tile; ignored unless in S_IDLE.
- i_tile_h  in  7  tile rows, 1..127, sampled at i_start.
- i_tile_w  in  7  tile columns, 1..127, sampled at i_start.
- i_valid  in  1  dense input word valid.
- i_data  in  DATA_W  signed dense activation.
- o_ready  out  1  block accepts i_data this cycle.
- o_valid  out  1  compressed entry valid (FIFO head).
- i_ready  in  1  downstream accepts entry.
- o_data  out  DATA_W  nonzero activation value.
- o_h  out  7  pixel row of the entry.
- o_w  out  7  pixel column of the entry.
- o_c_idx  out  5  channel index within the pixel.
- o_len  out  11  entries pushed for the current or last tile.
- o_overflow  out  1  sticky per tile; set when a nonzero arrives with o_len == CAP.
- o_busy  out  1  high in every state except S_IDLE.
- o_done  out  1  one-cycle pulse at tile completion.

## Operation
- Input order: c fastest, then w, then h. Counters c_r (0..CHANNELS-1), w_r, h_r, all cleared at i_start.
- Input handshake: a word is accepted when i_valid && o_ready.
  - o_ready = (state == S_RUN) && !fifo_full, where fifo_full is the registered full flag.
  - A pop in the same cycle does not raise o_ready.
- Every accepted word advances the counters.
- An accepted word with i_data ≠ 0 and o_len < CAP:
  - pushes {i_data, h_r, w_r, c_r} into the FIFO;
  - increments o_len.
- An accepted word with i_data ≠ 0 and o_len == CAP is dropped, sets o_overflow, and still advances the counters.
- Zero words are consumed and advance the counters; nothing is pushed.
- FSM states: S_IDLE, S_RUN, S_DRAIN, S_DONE.
  - S_IDLE → S_RUN on i_start. At the same time: latch the tile size, clear the counters, o_len and o_overflow.
  - S_RUN → S_DRAIN when the last word (h = H-1, w = W-1, c = CHANNELS-1) is accepted.
  - S_DRAIN → S_DONE when the FIFO is empty, including an empty FIFO on entry.
  - S_DONE → S_IDLE unconditionally. o_done = (state == S_DONE).
- The FIFO pops when o_valid && i_ready. Simultaneous push and pop in the same cycle leaves the occupancy unchanged.
- An all-zero tile produces no entries, o_len = 0 and a normal o_done.
- o_len and o_overflow hold after S_DONE until the next accepted i_start.

## Timing
- Reset values: state S_IDLE, FIFO empty, and all counters 0. o_ready, o_valid, o_len, o_overflow, o_busy and o_done are all 0. o_data, o_h, o_w and o_c_idx are 0.
- i_rst mid-tile aborts immediately: FIFO contents are lost and no o_done is issued.
- Push latency: an entry accepted in cycle N appears on o_valid in cycle N+1 if the FIFO was empty. o_data, o_h, o_w and o_c_idx are registered FIFO-head outputs.
- Throughput: 1 input word per cycle while i_ready stays high.
- With a stalled sink, o_ready drops the cycle after the FIFO reaches FIFO_DEPTH entries.
- o_len updates in the cycle after the push handshake.
- o_done rises the cycle after the FIFO becomes empty in S_DRAIN. With no pending entries, it rises 2 cycles after the last input is accepted.
- o_busy rises the cycle after i_start and falls together with o_done.

## Test plan
- Tile 1×1, CHANNELS=32, inputs c = 0..31 with data = c, i_ready=1 → 31 entries with c_idx 1..31, no entry for c=0, o_len=31, o_done once.
- Tile 2×2, all-zero input → no o_valid, o_len=0, o_done 2 cycles after the 128th accepted word.
- Tile 1×2, all data = -5, i_ready held low for 20 cycles → exactly 4 entries buffered, o_ready low. Release → all 64 entries arrive in order with correct (w, c) and o_data = -5.
- CAP=8, tile 1×1, 32 nonzero words → 8 entries (c 0..7), o_len=8, o_overflow=1, all 32 words consumed, o_done issued.
- i_start pulsed during S_RUN → ignored. i_rst asserted mid-tile → next cycle all outputs at reset values. A new tile afterwards completes correctly.
- Random data with ~70% zeros, random i_valid/i_ready, tile 3×5 → scoreboard matches the expected sparse list and o_len.
